fx_16bit_band_combiner: RTL and testbench

Recombines the four band-filter outputs of the 16-bit sign-magnitude FIR filter bank into one output sample. Each band sample is weighted by a programmable per-band gain and the four products are summed. One time-shared multiplier is used, driven by a small FSM. The block sits downstream of the four band FIR instances on the slow sample clock, and is the synthesis side of the analysis filter bank.

---
 rtl/fx16_pkg.sv | 43 ++++
 rtl/fx16_sm_mult.sv | 22 ++
 rtl/fx_16bit_band_combiner.sv | 114 +++++++++++
 tb/tb_fx_16bit_band_combiner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx16_pkg.sv
// Shared definitions for the 16-bit sign-magnitude datapath: format
// constants, conversion helpers and the band-combiner FSM state type.
// Optional build macro: BAND_COMBINER_ROUND_EN. When it is defined,
// tc_to_sm_sat rounds half away from zero. When it is not defined,
// tc_to_sm_sat truncates the magnitude, which rounds toward zero.
package fx16_pkg;

  localparam int SM_W      = 16;
  localparam int MAG_W     = 15;
  localparam int FRAC_BITS = 15;
  localparam int PROD_W    = 32;
  localparam int ACC_BITS  = 34;
  localparam logic [MAG_W-1:0] SM_MAX_MAG = 15'h7FFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  // Sign-magnitude to two's complement. Negative zero maps to zero.
  function automatic logic signed [SM_W-1:0] sm_to_tc(input logic [SM_W-1:0] sm);
    logic signed [SM_W-1:0] m;
    m = $signed({1'b0, sm[MAG_W-1:0]});
    return sm[SM_W-1] ? -m : m;
  endfunction

  // Q.30 accumulator to sign-magnitude Q0.15. The function saturates
  // the magnitude to 0x7FFF and never produces negative zero.
  function automatic logic [SM_W-1:0] tc_to_sm_sat(input logic signed [ACC_BITS-1:0] acc);
    logic [ACC_BITS-1:0] mag;
    logic [ACC_BITS-1:0] scaled;
    logic [MAG_W-1:0]    m;
    mag = acc[ACC_BITS-1] ? (~acc + ACC_BITS'(1)) : acc;
`ifdef BAND_COMBINER_ROUND_EN
    mag = mag + ACC_BITS'(32'd16384);
`endif
    scaled = mag >> FRAC_BITS;
    if (scaled > ACC_BITS'(SM_MAX_MAG)) m = SM_MAX_MAG;
    else                               m = scaled[MAG_W-1:0];
    return (m == '0) ? '0 : {acc[ACC_BITS-1], m};
  endfunction

endpackage

// File: rtl/fx16_sm_mult.sv
// Combinational 16x16 sign-magnitude multiplier. It forms a 15x15
// magnitude product and then negates it when the operand signs differ.
// The result is a signed 32-bit Q.30 value.
module fx16_sm_mult
  import fx16_pkg::*;
(
  input  logic [SM_W-1:0]          a,
  input  logic [SM_W-1:0]          b,
  output logic signed [PROD_W-1:0] prod
);

  logic [2*MAG_W-1:0] mag_p;
  logic               neg;

  // Unsigned magnitude product. The operand signs set the result sign.
  always_comb begin
    mag_p = (2*MAG_W)'(a[MAG_W-1:0]) * (2*MAG_W)'(b[MAG_W-1:0]);
    neg   = a[SM_W-1] ^ b[SM_W-1];
    prod  = neg ? -$signed({2'b00, mag_p}) : $signed({2'b00, mag_p});
  end

endmodule

// File: rtl/fx_16bit_band_combiner.sv
// Weights four sign-magnitude band samples by programmable gains and
// sums them, using one multiplier over four MAC cycles.
// Handshake: a sample set transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. The block does
// not queue a set that arrives while it is busy, so the source must hold
// its data until in_ready is high. out_valid is high for one cycle when
// out_sample updates, and there is no backpressure on the output.
// Optional build macro: BAND_COMBINER_ROUND_EN (round half away from zero).
module fx_16bit_band_combiner
  import fx16_pkg::*;
#(
  parameter int              NUM_BANDS  = 4,
  parameter logic [SM_W-1:0] GAIN_RESET = 16'h2000,
  parameter int              ACC_W      = 34
) (
  input  logic                      clk_slow,
  input  logic                      rst,
  input  logic [NUM_BANDS*SM_W-1:0] bands_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      gain_wr_en,
  input  logic [1:0]                gain_addr,
  input  logic [SM_W-1:0]           gain_data,
  output logic [SM_W-1:0]           out_sample,
  output logic                      out_valid,
  output logic                      state_dbg
);

  state_t                   state, state_nxt;
  logic [SM_W-1:0]          gain_reg  [NUM_BANDS];
  logic [SM_W-1:0]          gain_snap [NUM_BANDS];
  logic [SM_W-1:0]          band_q    [NUM_BANDS];
  logic [1:0]               k;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [PROD_W-1:0] prod;
  logic                     accept, last_mac;

  assign accept   = in_valid && (state == ST_IDLE);
  assign last_mac = (state == ST_MAC) && (k == 2'd3);

  fx16_sm_mult u_mult (
    .a    (band_q[k]),
    .b    (gain_snap[k]),
    .prod (prod)
  );

  assign acc_nxt = acc + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

  // State register
  always_ff @(posedge clk_slow) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: go to MAC on accept, return to IDLE after the fourth band
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_MAC;
      ST_MAC:  if (k == 2'd3) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state == ST_IDLE);
    state_dbg = state;
  end

  // Gain registers. A write can happen in any state. An accept in the
  // same cycle captures the old value.
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) gain_reg[i] <= GAIN_RESET;
    end else if (gain_wr_en) begin
      gain_reg[gain_addr] <= gain_data;
    end
  end

  // Latch samples and gains on accept, then accumulate one band per cycle
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        band_q[i]    <= '0;
        gain_snap[i] <= '0;
      end
      acc <= '0;
      k   <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        band_q[i]    <= bands_in[SM_W*i +: SM_W];
        gain_snap[i] <= gain_reg[i];
      end
      acc <= '0;
      k   <= '0;
    end else if (state == ST_MAC) begin
      acc <= acc_nxt;
      k   <= k + 2'd1;
    end
  end

  // Convert the result and register it when the last band is added
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid <= last_mac;
      if (last_mac) out_sample <= tc_to_sm_sat(ACC_BITS'(acc_nxt));
    end
  end

endmodule

// File: tb/tb_fx_16bit_band_combiner.sv
// Bench for fx_16bit_band_combiner. Driver tasks issue sample sets and
// gain writes. Each accepted set pushes a reference result into exp_q, and
// a negedge monitor pops and compares on every out_valid.
module tb_fx_16bit_band_combiner;

  logic        clk_slow = 1'b0;
  logic        rst;
  logic [63:0] bands_in;
  logic        in_valid;
  logic        in_ready;
  logic        gain_wr_en;
  logic [1:0]  gain_addr;
  logic [15:0] gain_data;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;
  int outs_seen = 0;
  int outs_expected = 0;
  logic [15:0] exp_q[$];
  logic [15:0] gains_m[4];

  fx_16bit_band_combiner dut (
    .clk_slow   (clk_slow),
    .rst        (rst),
    .bands_in   (bands_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .gain_wr_en (gain_wr_en),
    .gain_addr  (gain_addr),
    .gain_data  (gain_data),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_slow = ~clk_slow;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model(input logic [63:0] b, input logic [15:0] g0,
                                        input logic [15:0] g1, input logic [15:0] g2,
                                        input logic [15:0] g3);
    longint sum, m, r, p;
    logic [15:0] g[4];
    logic [15:0] s;
    logic [15:0] res;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      s = b[16*i +: 16];
      p = longint'(s[14:0]) * longint'(g[i][14:0]);
      if (s[15] != g[i][15]) sum = sum - p;
      else                   sum = sum + p;
    end
    m = (sum < 0) ? -sum : sum;
`ifdef BAND_COMBINER_ROUND_EN
    m = m + 16384;
`endif
    r = m / 32768;
    if (r > 32767) r = 32767;
    if (r == 0) res = 16'h0000;
    else        res = {(sum < 0) ? 1'b1 : 1'b0, r[14:0]};
    return res;
  endfunction

  function automatic logic [15:0] model_now(input logic [63:0] b);
    return model(b, gains_m[0], gains_m[1], gains_m[2], gains_m[3]);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest expectation
  always @(negedge clk_slow) begin
    if (out_valid === 1'b1) begin
      outs_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%h required=no_output", out_sample);
      end else begin
        check("out_sample", out_sample, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk_slow);
    rst = 1'b1; in_valid = 1'b0; gain_wr_en = 1'b0;
    outs_expected -= exp_q.size();
    exp_q.delete();
    for (int i = 0; i < 4; i++) gains_m[i] = 16'h2000;
    @(posedge clk_slow); #1;
    rst = 1'b0;
  endtask

  // Returns at a negedge where in_ready is high, or flags a timeout
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk_slow);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk_slow);
      n++;
    end
    if (n >= 20) check("ready_timeout", {15'b0, in_ready}, 16'h0001);
  endtask

  task automatic write_gain(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk_slow);
    gain_wr_en = 1'b1; gain_addr = a; gain_data = d;
    gains_m[a] = d;
    @(posedge clk_slow); #1;
    gain_wr_en = 1'b0;
  endtask

  // Issue one set, optionally with a gain write in the accept cycle
  task automatic send_set(input logic [63:0] b, input bit wr, input logic [1:0] a,
                          input logic [15:0] d);
    wait_ready();
    bands_in = b; in_valid = 1'b1;
    gain_wr_en = wr; gain_addr = a; gain_data = d;
    exp_q.push_back(model_now(b));
    outs_expected++;
    if (wr) gains_m[a] = d;
    @(posedge clk_slow); #1;
    in_valid = 1'b0; gain_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk_slow);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 16'(exp_q.size()), 16'h0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] b;
    logic [15:0] s;
    rst = 1'b1; in_valid = 1'b0; gain_wr_en = 1'b0;
    bands_in = '0; gain_addr = '0; gain_data = '0;
    for (int i = 0; i < 4; i++) gains_m[i] = 16'h2000;
    repeat (3) @(posedge clk_slow);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk_slow);
    check("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_out_sample", out_sample, 16'h0000);
    check("rst_in_ready", {15'b0, in_ready}, 16'h0001);
    check("rst_state", {15'b0, state_dbg}, 16'h0000);

    // 1: default gains, full-scale bands, with latency and ready timing
    send_set({4{16'h7FFF}}, 1'b0, 2'd0, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_slow);
      check("busy_in_ready", {15'b0, in_ready}, 16'h0000);
      check("busy_out_valid", {15'b0, out_valid}, 16'h0000);
    end
    @(negedge clk_slow);
    check("c5_out_valid", {15'b0, out_valid}, 16'h0001);
    check("c5_in_ready", {15'b0, in_ready}, 16'h0001);
    check("t1_value", out_sample, 16'h7FFF);
    drain();

    // 2: saturation, positive and negative
    for (int i = 0; i < 4; i++) write_gain(2'(i), 16'h7FFF);
    send_set({4{16'h4000}}, 1'b0, 2'd0, 16'h0);
    send_set({4{16'hC000}}, 1'b0, 2'd0, 16'h0);
    drain();

    // 3: cancellation must give positive zero
    send_set(64'h0000_0000_C000_4000, 1'b0, 2'd0, 16'h0);
    drain();
    check("t3_no_neg_zero", out_sample, 16'h0000);

    // 4: rounding behaviour on a half-LSB product
    write_gain(2'd0, 16'h4000);
    for (int i = 1; i < 4; i++) write_gain(2'(i), 16'h0000);
    send_set(64'h0000_0000_0000_0001, 1'b0, 2'd0, 16'h0);
    send_set(64'h0000_0000_0000_8001, 1'b0, 2'd0, 16'h0);
    send_set(64'h0000_0000_0000_8000, 1'b0, 2'd0, 16'h0);
    drain();

    // 5: same-cycle gain write, in_valid held high across two accepts
    do_reset();
    b = 64'h0000_0000_0000_7FFF;
    wait_ready();
    bands_in = b; in_valid = 1'b1;
    gain_wr_en = 1'b1; gain_addr = 2'd0; gain_data = 16'h0000;
    exp_q.push_back(16'h1FFF); outs_expected++;
    gains_m[0] = 16'h0000;
    @(posedge clk_slow); #1;
    gain_wr_en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_slow);
      check("held_busy_ready", {15'b0, in_ready}, 16'h0000);
    end
    @(negedge clk_slow);
    check("held_c5_ready", {15'b0, in_ready}, 16'h0001);
    exp_q.push_back(model_now(b)); outs_expected++;
    @(posedge clk_slow); #1;
    in_valid = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk_slow);
      check("held2_busy_ready", {15'b0, in_ready}, 16'h0000);
    end
    drain();
    check("t5_second_zero", out_sample, 16'h0000);

    // 6: reset in the middle of a computation
    for (int i = 0; i < 4; i++) write_gain(2'(i), 16'h7FFF);
    send_set(64'h0000_0000_0000_7FFF, 1'b0, 2'd0, 16'h0);
    @(negedge clk_slow);
    do_reset();
    @(negedge clk_slow);
    check("midrst_in_ready", {15'b0, in_ready}, 16'h0001);
    check("midrst_out_sample", out_sample, 16'h0000);
    repeat (8) @(negedge clk_slow);
    send_set(64'h0000_0000_0000_7FFF, 1'b0, 2'd0, 16'h0);
    drain();
    check("t6_gain_reset", out_sample, 16'h1FFF);

    // Randomized sets and gain writes
    for (int it = 0; it < 60; it++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        write_gain(2'($urandom_range(0, 3)), 16'($urandom));
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0: s = 16'h8000;
          1: s = 16'h7FFF;
          2: s = 16'hFFFF;
          default: s = 16'($urandom);
        endcase
        b[16*i +: 16] = s;
      end
      if ($urandom_range(0, 3) == 0)
        send_set(b, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
      else
        send_set(b, 1'b0, 2'd0, 16'h0);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    // Final report
    repeat (3) @(negedge clk_slow);
    check("output_count", 16'(outs_seen), 16'(outs_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
